// File: rtl/chroma_downsampling_controller_pkg.sv
// Shared definitions for the chroma downsampling controller.
//   state_t    : controller FSM state (also exported on dbg_state)
//   DEF_*      : default frame geometry and sample width
//   cnt_width  : counter/address width for a range of n values (minimum 1 bit)
package downsampling_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_EVEN = 2'd1,
    RUN_ODD  = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  localparam int DEF_IMG_W = 320;
  localparam int DEF_IMG_H = 240;
  localparam int DEF_DW    = 8;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chroma_downsampling_controller_line_buffer.sv
// ds_line_buffer: one row of horizontally decimated samples.
//   clk    : write clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : asynchronous read address
//   rdata  : asynchronous read data
// No reset: contents are always written in an even row before being read in
// the following odd row.
module ds_line_buffer #(
  parameter int DEPTH = 160,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/chroma_downsampling_controller.sv
// chroma_downsampling_controller: streaming 4:4:4 -> 4:2:0 chroma decimator.
// One chroma plane arrives raster-scan; each odd column produces a horizontal
// [1 2 1]/4 value. Even rows park it in the line buffer, odd rows average it
// with the parked value and emit one output sample.
//   clk, rst          : clock, asynchronous active-high reset
//   start             : begins a frame when IDLE
//   in_valid/in_ready/in_data            : input sample stream
//   out_valid/out_ready/out_data         : decimated sample stream
//   out_eol, out_eof  : last sample of output row / frame
//   busy              : high while consuming input rows
//   done              : one-cycle pulse after the last output is accepted
//   dbg_state         : current FSM state
//
// Handshake: a transfer happens on a cycle where valid & ready are both high.
// A producer holds valid and its data stable until the transfer; ready may
// change freely. out_* hold while out_valid & !out_ready, and in_ready stays
// low so no new output can overwrite the pending one.
module chroma_downsampling_controller
  import downsampling_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int DW    = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_eol,
  output logic          out_eof,
  output logic          busy,
  output logic          done,
  output state_t        dbg_state
);

  localparam int COL_W = cnt_width(IMG_W);
  localparam int ROW_W = cnt_width(IMG_H);
  localparam int AW    = COL_W - 1;

  state_t            state;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [DW-1:0]     tap_even;   // p[c-1] when c is odd
  logic [DW-1:0]     tap_odd;    // p[c-2] when c is odd (c >= 3)

  logic              xfer;
  logic              last_col;
  logic              last_row;
  logic [DW-1:0]     left_tap;
  logic [DW+1:0]     h_sum;
  logic [DW-1:0]     h_val;
  logic [DW-1:0]     lb_rdata;
  logic [DW:0]       v_sum;
  logic              lb_we;
  logic [AW-1:0]     lb_addr;

  assign busy      = (state == RUN_EVEN) || (state == RUN_ODD);
  assign in_ready  = busy & (~out_valid | out_ready);
  assign xfer      = in_valid & in_ready;
  assign last_col  = (col == COL_W'(IMG_W - 1));
  assign last_row  = (row == ROW_W'(IMG_H - 1));
  assign dbg_state = state;

  // Column 1 has no p[-1]; replicate p[0], which is the even tap there.
  assign left_tap = (col == COL_W'(1)) ? tap_even : tap_odd;
  assign h_sum    = {2'b00, left_tap} + {1'b0, tap_even, 1'b0}
                  + {2'b00, in_data} + (DW+2)'(2);
  assign h_val    = h_sum[DW+1:2];
  assign v_sum    = {1'b0, lb_rdata} + {1'b0, h_val} + (DW+1)'(1);

  assign lb_addr  = col[COL_W-1:1];
  assign lb_we    = xfer & col[0] & (state == RUN_EVEN);

  ds_line_buffer #(
    .DEPTH (IMG_W / 2),
    .AW    (AW),
    .DW    (DW)
  ) u_line_buffer (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (h_val),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      tap_even  <= '0;
      tap_odd   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN_EVEN;
            col   <= '0;
            row   <= '0;
          end
        end

        RUN_EVEN, RUN_ODD: begin
          if (xfer) begin
            if (col[0]) tap_odd  <= in_data;
            else        tap_even <= in_data;

            // A new output may load in the same cycle the previous one is
            // accepted, since in_ready already required out_ready.
            if (col[0] && (state == RUN_ODD)) begin
              out_valid <= 1'b1;
              out_data  <= v_sum[DW:1];
              out_eol   <= last_col;
              out_eof   <= last_col & last_row;
            end

            if (last_col) begin
              col <= '0;
              if (last_row) begin
                row   <= '0;
                state <= DRAIN;
              end else begin
                row   <= row + ROW_W'(1);
                state <= (state == RUN_EVEN) ? RUN_ODD : RUN_EVEN;
              end
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end

        DRAIN: begin
          // The last odd-row transfer always leaves a pending output here.
          if (out_valid && out_ready) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chroma_downsampling_controller.sv
module tb_chroma_downsampling_controller;
  import downsampling_pkg::*;

  localparam int IMG_W = 8;
  localparam int IMG_H = 4;
  localparam int DW    = 8;
  localparam int N_OUT = (IMG_W / 2) * (IMG_H / 2);

  logic          clk;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_eol;
  logic          out_eof;
  logic          busy;
  logic          done;
  state_t        dbg_state;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: {eof, eol, data} per expected output, in order.
  logic [DW+1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int            out_cnt  = 0;
  int            done_cnt = 0;
  int            rmode    = 0;   // 0: ready always, 1: random, 2: held low
  bit            mon_en   = 1'b1;

  int frame [IMG_H][IMG_W];

  chroma_downsampling_controller #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .DW    (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_eol   (out_eol),
    .out_eof   (out_eof),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- out_ready driver ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rmode == 0)      out_ready = 1'b1;
      else if (rmode == 1) out_ready = ($urandom_range(0, 3) != 0);
      else                 out_ready = 1'b0;
    end
  end

  // ---------------- output monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mon_en && out_valid && out_ready) begin
      logic [DW+1:0] e;
      out_cnt++;
      got_q.push_back(out_data);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected: got data=%0d eol=%0b eof=%0b, required no output",
                 out_data, out_eol, out_eof);
      end else begin
        e = exp_q.pop_front();
        if ({out_eof, out_eol, out_data} !== e) begin
          failures++;
          $display("FAIL out_sample #%0d: got data=%0d eol=%0b eof=%0b, required data=%0d eol=%0b eof=%0b",
                   out_cnt, out_data, out_eol, out_eof, e[DW-1:0], e[DW], e[DW+1]);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int h_ref(input int r, input int c);
    int left;
    left = (c == 1) ? frame[r][0] : frame[r][c-2];
    return (left + 2 * frame[r][c-1] + frame[r][c] + 2) / 4;
  endfunction

  task automatic build_expected();
    exp_q.delete();
    for (int r = 0; r < IMG_H; r += 2) begin
      for (int c = 1; c < IMG_W; c += 2) begin
        int v;
        logic eol, eof;
        v   = (h_ref(r, c) + h_ref(r + 1, c) + 1) / 2;
        eol = (c == IMG_W - 1);
        eof = eol && (r == IMG_H - 2);
        exp_q.push_back({eof, eol, DW'(v)});
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_sample(input int d, input bit spam);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = DW'(d);
    if (spam) start = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 1000) begin
        checks++;
        failures++;
        $display("FAIL in_ready_timeout: in_ready stayed 0 for 1000 cycles, required 1");
        break;
      end
    end
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic drive_frame(input bit gaps, input bit spam);
    int guard;
    build_expected();
    out_cnt  = 0;
    done_cnt = 0;
    got_q.delete();
    pulse_start();
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
        if (gaps) #1;
        push_sample(frame[r][c], spam && (c == 2));
      end
    end
    guard = 0;
    while (done_cnt == 0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("FAIL done_count: got %0d pulses, required 1", done_cnt);
    end
    checks++;
    if (out_cnt !== N_OUT) begin
      failures++;
      $display("FAIL out_count: got %0d outputs, required %0d", out_cnt, N_OUT);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL exp_leftover: got %0d unmatched expected outputs, required 0", exp_q.size());
    end
    checks++;
    if (dbg_state !== IDLE || busy !== 1'b0) begin
      failures++;
      $display("FAIL end_idle: got state=%0d busy=%0b, required state=0 busy=0", dbg_state, busy);
    end
  endtask

  task automatic fill_const(input int v);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) frame[r][c] = v;
  endtask

  task automatic fill_random();
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) frame[r][c] = int'($urandom_range(0, 255));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, busy, done, out_eol, out_eof} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got valid=%0b ready=%0b busy=%0b done=%0b eol=%0b eof=%0b, required all 0",
               out_valid, in_ready, busy, done, out_eol, out_eof);
    end
    checks++;
    if (out_data !== '0 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL reset_data_state: got data=%0d state=%0d, required 0 and 0", out_data, dbg_state);
    end
  endtask

  task automatic test_constant();
    rmode = 0;
    fill_const(100);
    drive_frame(1'b0, 1'b0);
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== DW'(100)) begin
        failures++;
        $display("FAIL const_value[%0d]: got %0d, required 100", i, got_q[i]);
      end
    end
  endtask

  task automatic test_ramp();
    int first_row [4];
    first_row = '{0, 2, 4, 6};
    rmode = 0;
    fill_random();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < IMG_W; c++) frame[r][c] = c;
    drive_frame(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_q.size() <= i || got_q[i] !== DW'(first_row[i])) begin
        failures++;
        $display("FAIL ramp_row0[%0d]: got %0d, required %0d", i,
                 (got_q.size() > i) ? int'(got_q[i]) : -1, first_row[i]);
      end
    end
  endtask

  task automatic test_vertical_avg();
    rmode = 0;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) frame[r][c] = (r % 2 == 0) ? 10 : 21;
    drive_frame(1'b0, 1'b0);
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== DW'(16)) begin
        failures++;
        $display("FAIL vavg_value[%0d]: got %0d, required 16", i, got_q[i]);
      end
    end
  endtask

  task automatic test_random_backpressure();
    for (int n = 0; n < 4; n++) begin
      rmode = (n == 0) ? 0 : 1;
      fill_random();
      if (n == 3) fill_const(255);
      drive_frame(n[0], 1'b0);
    end
    rmode = 0;
  endtask

  task automatic test_stall();
    rmode = 2;
    fill_random();
    fork
      drive_frame(1'b0, 1'b0);
      begin
        int guard;
        logic [DW-1:0] d0;
        logic e0;
        guard = 0;
        do begin
          @(negedge clk);
          guard++;
        end while (!out_valid && guard < 500);
        d0 = out_data;
        e0 = out_eol;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          checks++;
          if (out_valid !== 1'b1 || out_data !== d0 || out_eol !== e0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold[%0d]: got valid=%0b data=%0d eol=%0b in_ready=%0b, required 1 %0d %0b 0",
                     k, out_valid, out_data, out_eol, in_ready, d0, e0);
          end
        end
        rmode = 0;
      end
    join
  endtask

  task automatic test_reset_mid_frame();
    rmode = 0;
    fill_const(100);
    build_expected();
    pulse_start();
    for (int i = 0; i < IMG_W + 3; i++) push_sample(100, 1'b0);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL mid_reset: got valid=%0b busy=%0b in_ready=%0b state=%0d, required 0 0 0 0",
               out_valid, busy, in_ready, dbg_state);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    drive_frame(1'b0, 1'b0);
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== DW'(100)) begin
        failures++;
        $display("FAIL post_reset_value[%0d]: got %0d, required 100", i, got_q[i]);
      end
    end
  endtask

  task automatic test_ignored_inputs();
    rmode = 0;
    in_valid = 1'b1;
    in_data  = DW'($urandom_range(0, 255));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || dbg_state !== IDLE || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL idle_in_valid[%0d]: got in_ready=%0b state=%0d valid=%0b, required 0 0 0",
                 k, in_ready, dbg_state, out_valid);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    fill_random();
    drive_frame(1'b1, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    test_reset();
    test_constant();
    test_ramp();
    test_vertical_avg();
    test_random_backpressure();
    test_stall();
    test_reset_mid_frame();
    test_ignored_inputs();
    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
